// File: rtl/cache_bus_pkg.sv
// Shared definitions for the cache-bus memory responder: FSM encoding,
// the one legal beat size, and the beat-counter width.
package cache_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_WAIT = 3'd1,
    S_RD_BEAT = 3'd2,
    S_WR_BEAT = 3'd3,
    S_WR_RESP = 3'd4
  } state_t;

  localparam logic [2:0] SIZE_WORD = 3'b010;
  localparam int         CNT_W     = 8;

endpackage

// File: rtl/resp_sram.sv
// Word-wide storage with one registered-address read port and one
// byte-lane-masked write port. Contents are never reset.
module resp_sram #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [3:0]    wr_be
);

  logic [31:0]   mem [0:(1<<AW)-1];
  logic [AW-1:0] rd_addr_q;

  always_ff @(posedge clk) begin
    rd_addr_q <= rd_addr;
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign rd_data = mem[rd_addr_q];

endmodule

// File: rtl/cache_bus_mem_responder.sv
// Burst memory responder for the cache bus: accepts one address at a time,
// then streams read beats or absorbs lane-masked write beats and a response.
module cache_bus_mem_responder
  import cache_bus_pkg::*;
#(
  parameter int MEM_AW  = 12,
  parameter int RD_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] AXI_addr,
  input  logic        AXI_addr_valid,
  input  logic        AXI_we,
  input  logic [2:0]  AXI_size,
  input  logic [7:0]  AXI_lens,
  input  logic        AXI_rd_rready,
  output logic        AXI_rd_dready,
  output logic        AXI_rd_last,
  output logic [31:0] AXI_rd_data,
  output logic        AXI_rd_addr_clear,
  input  logic [31:0] AXI_wr_data,
  input  logic        AXI_wr_dready,
  input  logic [3:0]  AXI_byte_enable,
  input  logic        AXI_wr_last,
  input  logic        AXI_response_rready,
  output logic        AXI_wr_next,
  output logic        AXI_wr_ok,
  output logic        AXI_wr_addr_clear,
  output logic        proto_err
);

  localparam logic [2:0]        WAIT_LAST = 3'(RD_WAIT > 0 ? RD_WAIT - 1 : 0);
  localparam logic [MEM_AW-1:0] ADDR_ONE  = MEM_AW'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [2:0]         wait_cnt_q, wait_cnt_d;
  logic               rd_clr_q, rd_clr_d;
  logic               wr_clr_q, wr_clr_d;
  logic               perr_q, perr_d;
  logic [MEM_AW-1:0]  beat_addr_q, beat_addr_d;
  logic [CNT_W-1:0]   lens_q, lens_d;
  logic               mem_we;
  logic [31:0]        sram_rdata;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^{AXI_addr[1:0], AXI_addr[31:MEM_AW+2]};

  // Control state: cleared asynchronously so a reset abandons any burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      beat_cnt_q <= '0;
      wait_cnt_q <= '0;
      rd_clr_q   <= 1'b0;
      wr_clr_q   <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      rd_clr_q   <= rd_clr_d;
      wr_clr_q   <= wr_clr_d;
      perr_q     <= perr_d;
    end
  end

  always_ff @(posedge clk) begin
    beat_addr_q <= beat_addr_d;
    lens_q      <= lens_d;
  end

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    beat_addr_d = beat_addr_q;
    lens_d      = lens_q;
    rd_clr_d    = 1'b0;
    wr_clr_d    = 1'b0;
    perr_d      = 1'b0;
    mem_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (AXI_addr_valid) begin
          beat_addr_d = AXI_addr[MEM_AW+1:2];
          lens_d      = AXI_lens;
          beat_cnt_d  = '0;
          wait_cnt_d  = '0;
          perr_d      = (AXI_size != SIZE_WORD);
          if (AXI_we) begin
            wr_clr_d = 1'b1;
            state_d  = S_WR_BEAT;
          end else begin
            rd_clr_d = 1'b1;
            state_d  = (RD_WAIT == 0) ? S_RD_BEAT : S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        wait_cnt_d = wait_cnt_q + 3'd1;
        if (wait_cnt_q == WAIT_LAST) state_d = S_RD_BEAT;
      end
      S_RD_BEAT: begin
        if (AXI_rd_rready) begin
          beat_addr_d = beat_addr_q + ADDR_ONE;
          beat_cnt_d  = beat_cnt_q + CNT_ONE;
          if (beat_cnt_q == lens_q) state_d = S_IDLE;
        end
      end
      S_WR_BEAT: begin
        if (AXI_wr_dready) begin
          mem_we      = 1'b1;
          beat_addr_d = beat_addr_q + ADDR_ONE;
          beat_cnt_d  = beat_cnt_q + CNT_ONE;
          perr_d      = (AXI_wr_last != (beat_cnt_q == lens_q));
          if (beat_cnt_q == lens_q) state_d = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (AXI_response_rready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    AXI_rd_dready = 1'b0;
    AXI_rd_last   = 1'b0;
    AXI_rd_data   = '0;
    AXI_wr_next   = 1'b0;
    AXI_wr_ok     = 1'b0;
    case (state_q)
      S_RD_BEAT: begin
        AXI_rd_dready = 1'b1;
        AXI_rd_last   = (beat_cnt_q == lens_q);
        AXI_rd_data   = sram_rdata;
      end
      S_WR_BEAT: AXI_wr_next = 1'b1;
      S_WR_RESP: AXI_wr_ok   = 1'b1;
      default: ;
    endcase
  end

  assign AXI_rd_addr_clear = rd_clr_q;
  assign AXI_wr_addr_clear = wr_clr_q;
  assign proto_err         = perr_q;

  // The read address tracks the next-cycle beat address, so the registered
  // SRAM read lands on the current beat and holds while stalled.
  resp_sram #(.AW(MEM_AW)) u_sram (
    .clk     (clk),
    .rd_addr (beat_addr_d),
    .rd_data (sram_rdata),
    .wr_en   (mem_we),
    .wr_addr (beat_addr_q),
    .wr_data (AXI_wr_data),
    .wr_be   (AXI_byte_enable)
  );

endmodule

// File: tb/tb_cache_bus_mem_responder.sv
// Scoreboard bench: two responders (12-bit and 4-bit address) sharing one
// request bus, steered by sel4; a negedge monitor pops expected beats.
module tb_cache_bus_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel4 = 1'b0;
  logic [31:0] AXI_addr = '0;
  logic        AXI_addr_valid = 1'b0;
  logic        AXI_we = 1'b0;
  logic [2:0]  AXI_size = 3'b010;
  logic [7:0]  AXI_lens = '0;
  logic        AXI_rd_rready = 1'b0;
  logic [31:0] AXI_wr_data = '0;
  logic        AXI_wr_dready = 1'b0;
  logic [3:0]  AXI_byte_enable = 4'hF;
  logic        AXI_wr_last = 1'b0;
  logic        AXI_response_rready = 1'b0;

  logic        a_rd_dready, a_rd_last, a_rd_clr, a_wr_next, a_wr_ok, a_wr_clr, a_perr;
  logic [31:0] a_rd_data;
  logic        b_rd_dready, b_rd_last, b_rd_clr, b_wr_next, b_wr_ok, b_wr_clr, b_perr;
  logic [31:0] b_rd_data;
  logic        m_rd_dready, m_rd_last, m_rd_clr, m_wr_next, m_wr_ok, m_wr_clr, m_perr;
  logic [31:0] m_rd_data;

  always #5 clk = ~clk;

  cache_bus_mem_responder #(.MEM_AW(12), .RD_WAIT(1)) dut (
    .clk(clk), .rst(rst), .AXI_addr(AXI_addr), .AXI_addr_valid(AXI_addr_valid && !sel4),
    .AXI_we(AXI_we), .AXI_size(AXI_size), .AXI_lens(AXI_lens), .AXI_rd_rready(AXI_rd_rready),
    .AXI_rd_dready(a_rd_dready), .AXI_rd_last(a_rd_last), .AXI_rd_data(a_rd_data),
    .AXI_rd_addr_clear(a_rd_clr), .AXI_wr_data(AXI_wr_data), .AXI_wr_dready(AXI_wr_dready),
    .AXI_byte_enable(AXI_byte_enable), .AXI_wr_last(AXI_wr_last),
    .AXI_response_rready(AXI_response_rready), .AXI_wr_next(a_wr_next), .AXI_wr_ok(a_wr_ok),
    .AXI_wr_addr_clear(a_wr_clr), .proto_err(a_perr));

  cache_bus_mem_responder #(.MEM_AW(4), .RD_WAIT(0)) dut4 (
    .clk(clk), .rst(rst), .AXI_addr(AXI_addr), .AXI_addr_valid(AXI_addr_valid && sel4),
    .AXI_we(AXI_we), .AXI_size(AXI_size), .AXI_lens(AXI_lens), .AXI_rd_rready(AXI_rd_rready),
    .AXI_rd_dready(b_rd_dready), .AXI_rd_last(b_rd_last), .AXI_rd_data(b_rd_data),
    .AXI_rd_addr_clear(b_rd_clr), .AXI_wr_data(AXI_wr_data), .AXI_wr_dready(AXI_wr_dready),
    .AXI_byte_enable(AXI_byte_enable), .AXI_wr_last(AXI_wr_last),
    .AXI_response_rready(AXI_response_rready), .AXI_wr_next(b_wr_next), .AXI_wr_ok(b_wr_ok),
    .AXI_wr_addr_clear(b_wr_clr), .proto_err(b_perr));

  assign m_rd_dready = sel4 ? b_rd_dready : a_rd_dready;
  assign m_rd_last   = sel4 ? b_rd_last   : a_rd_last;
  assign m_rd_data   = sel4 ? b_rd_data   : a_rd_data;
  assign m_rd_clr    = sel4 ? b_rd_clr    : a_rd_clr;
  assign m_wr_next   = sel4 ? b_wr_next   : a_wr_next;
  assign m_wr_ok     = sel4 ? b_wr_ok     : a_wr_ok;
  assign m_wr_clr    = sel4 ? b_wr_clr    : a_wr_clr;
  assign m_perr      = sel4 ? b_perr      : a_perr;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t exp_rd[$];
  int    exp_wr[$];
  int    n_chk = 0;
  int    n_err = 0;
  int    rd_beats = 0, rd_clr_cnt = 0, wr_clr_cnt = 0, perr_cnt = 0, wr_ok_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: counts pulses, pops the scoreboard on every handshake,
  // and checks that a stalled beat holds its data and last flag.
  initial begin
    beat_t       e;
    bit          hold_chk;
    logic [31:0] hold_data;
    logic        hold_last;
    hold_chk = 0; hold_data = '0; hold_last = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_chk = 0;
      end else begin
        if (m_rd_clr) rd_clr_cnt++;
        if (m_wr_clr) wr_clr_cnt++;
        if (m_perr)   perr_cnt++;
        if (m_rd_dready) begin
          if (hold_chk) begin
            check("rd_hold_data", m_rd_data, hold_data);
            check("rd_hold_last", 32'(m_rd_last), 32'(hold_last));
          end
          if (AXI_rd_rready) begin
            rd_beats++;
            hold_chk = 0;
            if (exp_rd.size() == 0) begin
              check("rd_unexpected_beat", m_rd_data, 32'hDEAD_BEEF);
            end else begin
              e = exp_rd.pop_front();
              check("rd_data", m_rd_data, e.data);
              check("rd_last", 32'(m_rd_last), 32'(e.last));
            end
          end else begin
            hold_chk  = 1;
            hold_data = m_rd_data;
            hold_last = m_rd_last;
          end
        end else begin
          hold_chk = 0;
        end
        if (m_wr_ok && AXI_response_rready) begin
          wr_ok_cnt++;
          if (exp_wr.size() == 0) check("wr_ok_unexpected", 32'(m_wr_ok), 32'd0);
          else void'(exp_wr.pop_front());
        end
      end
    end
  end

  task automatic do_write(input bit s4, input logic [31:0] addr, input logic [7:0] lens,
                          input logic [31:0] base, input logic [31:0] step,
                          input logic [3:0] be, input int bad_beat, input int resp_delay);
    int cyc, wclr0, ok0;
    sel4 = s4; wclr0 = wr_clr_cnt; ok0 = wr_ok_cnt;
    exp_wr.push_back(1);
    AXI_addr = addr; AXI_we = 1'b1; AXI_size = 3'b010; AXI_lens = lens;
    AXI_byte_enable = be; AXI_addr_valid = 1'b1;
    @(posedge clk); #1;
    AXI_addr_valid = 1'b0;
    for (int i = 0; i <= int'(lens); i++) begin
      cyc = 0;
      while (!m_wr_next && cyc < 20) begin @(posedge clk); #1; cyc++; end
      check("wr_next", 32'(m_wr_next), 32'd1);
      AXI_wr_data   = base + step * 32'(i);
      AXI_wr_dready = 1'b1;
      AXI_wr_last   = (i == int'(lens)) != (i == bad_beat);
      @(posedge clk); #1;
    end
    AXI_wr_dready = 1'b0; AXI_wr_last = 1'b0;
    for (int k = 0; k < resp_delay; k++) begin
      check("wr_ok_hold", 32'(m_wr_ok), 32'd1);
      @(posedge clk); #1;
    end
    cyc = 0;
    while (!m_wr_ok && cyc < 20) begin @(posedge clk); #1; cyc++; end
    AXI_response_rready = 1'b1;
    @(posedge clk); #1;
    AXI_response_rready = 1'b0;
    check("wr_ok_count", 32'(wr_ok_cnt - ok0), 32'd1);
    check("wr_addr_clear", 32'(wr_clr_cnt - wclr0), 32'd1);
    check("wr_ok_after", 32'(m_wr_ok), 32'd0);
  endtask

  task automatic do_read(input bit s4, input logic [31:0] addr, input logic [7:0] lens,
                         input logic [2:0] size, input bit stall, input int exp_idle);
    int start, nb, idle, cyc, rclr0;
    bit seen;
    logic [3:0] pat;
    pat = 4'b1001;
    sel4 = s4; start = rd_beats; rclr0 = rd_clr_cnt;
    AXI_addr = addr; AXI_we = 1'b0; AXI_size = size; AXI_lens = lens;
    AXI_addr_valid = 1'b1; AXI_rd_rready = 1'b1;
    @(posedge clk); #1;
    AXI_addr_valid = 1'b0;
    nb = int'(lens) + 1; idle = 0; seen = 0; cyc = 0;
    while (rd_beats - start < nb && cyc < 400) begin
      if (!seen) begin
        if (m_rd_dready) seen = 1; else idle++;
      end
      AXI_rd_rready = stall ? pat[cyc % 4] : 1'b1;
      cyc++;
      @(posedge clk); #1;
    end
    AXI_rd_rready = 1'b0;
    AXI_size = 3'b010;
    check("rd_beat_total", 32'(rd_beats - start), 32'(nb));
    check("rd_wait_cycles", 32'(idle), 32'(exp_idle));
    check("rd_addr_clear", 32'(rd_clr_cnt - rclr0), 32'd1);
    check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    check("rd_dready_after", 32'(m_rd_dready), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_dready"}, 32'(m_rd_dready), 32'd0);
    check({tag, "_rd_last"},   32'(m_rd_last),   32'd0);
    check({tag, "_rd_data"},   m_rd_data,        32'd0);
    check({tag, "_rd_clr"},    32'(m_rd_clr),    32'd0);
    check({tag, "_wr_next"},   32'(m_wr_next),   32'd0);
    check({tag, "_wr_ok"},     32'(m_wr_ok),     32'd0);
    check({tag, "_wr_clr"},    32'(m_wr_clr),    32'd0);
    check({tag, "_perr"},      32'(m_perr),      32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, start, cyc;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;

    // Preload words 0x10..0x1F with their offset.
    p0 = perr_cnt;
    do_write(1'b0, 32'h40, 8'd15, 32'd0, 32'd1, 4'hF, -1, 0);
    check("preload_perr", 32'(perr_cnt - p0), 32'd0);

    for (int i = 0; i < 16; i++) exp_rd.push_back('{data: 32'(i), last: (i == 15)});
    do_read(1'b0, 32'h40, 8'd15, 3'b010, 1'b0, 1);

    for (int i = 0; i < 16; i++) exp_rd.push_back('{data: 32'(i), last: (i == 15)});
    do_read(1'b0, 32'h40, 8'd15, 3'b010, 1'b1, 1);

    // Byte-lane masking over a zeroed region.
    do_write(1'b0, 32'h80, 8'd3, 32'd0, 32'd0, 4'hF, -1, 0);
    do_write(1'b0, 32'h80, 8'd3, 32'hAABBCCDD, 32'd0, 4'b0101, -1, 3);
    for (int i = 0; i < 4; i++) exp_rd.push_back('{data: 32'h00BB00DD, last: (i == 3)});
    do_read(1'b0, 32'h80, 8'd3, 3'b010, 1'b0, 1);

    // Early wr_last: one protocol error, both beats still written.
    p0 = perr_cnt;
    do_write(1'b0, 32'hC0, 8'd1, 32'h11110000, 32'd1, 4'hF, 0, 1);
    check("early_last_perr", 32'(perr_cnt - p0), 32'd1);
    check("early_last_resp_q", 32'(exp_wr.size()), 32'd0);
    exp_rd.push_back('{data: 32'h11110000, last: 1'b0});
    exp_rd.push_back('{data: 32'h11110001, last: 1'b1});
    do_read(1'b0, 32'hC0, 8'd1, 3'b010, 1'b0, 1);

    // Non-word size: error pulse, burst still proceeds as a word beat.
    p0 = perr_cnt;
    exp_rd.push_back('{data: 32'd2, last: 1'b1});
    do_read(1'b0, 32'h48, 8'd0, 3'b000, 1'b0, 1);
    check("size_perr", 32'(perr_cnt - p0), 32'd1);

    // 16-word memory: fill word k with 0x400+k, then read across the wrap.
    do_write(1'b1, 32'h0, 8'd15, 32'h400, 32'd1, 4'hF, -1, 0);
    exp_rd.push_back('{data: 32'h40E, last: 1'b0});
    exp_rd.push_back('{data: 32'h40F, last: 1'b0});
    exp_rd.push_back('{data: 32'h400, last: 1'b0});
    exp_rd.push_back('{data: 32'h401, last: 1'b1});
    do_read(1'b1, 32'h38, 8'd3, 3'b010, 1'b0, 0);

    // Reset in the middle of beat 5 of a 16-beat read.
    sel4 = 1'b0; start = rd_beats;
    for (int i = 0; i < 5; i++) exp_rd.push_back('{data: 32'(i), last: 1'b0});
    AXI_addr = 32'h40; AXI_we = 1'b0; AXI_size = 3'b010; AXI_lens = 8'd15;
    AXI_addr_valid = 1'b1; AXI_rd_rready = 1'b1;
    @(posedge clk); #1;
    AXI_addr_valid = 1'b0;
    cyc = 0;
    while (rd_beats - start < 5 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    check("mid_rst_beats_before", 32'(rd_beats - start), 32'd5);
    check("mid_rst_data_before", m_rd_data, 32'd5);
    #2 rst = 1'b1;
    #1;
    check_outputs_zero("mid_rst");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    AXI_rd_rready = 1'b0;
    exp_rd.push_back('{data: 32'd1, last: 1'b1});
    do_read(1'b0, 32'h44, 8'd0, 3'b010, 1'b0, 1);

    repeat (3) @(posedge clk);
    #1;
    check("final_rd_queue", 32'(exp_rd.size()), 32'd0);
    check("final_wr_queue", 32'(exp_wr.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
